// File: rtl/dc_data_array_param.sv
// N-way byte-maskable data line store with registered reads, a one-entry
// write staging buffer (read bypass, anti-starvation drain) and a zeroing sweep after reset.

module dc_data_array_way #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_BYTES = 16,
  parameter int IDX_W      = 4
) (
  input  logic                        clk_i,
  input  logic                        we_i,
  input  logic [IDX_W-1:0]            widx_i,
  input  logic [LINE_BYTES-1:0]       wbe_i,
  input  logic [LINE_BYTES-1:0][7:0]  wdata_i,
  input  logic [IDX_W-1:0]            ridx_i,
  output logic [LINE_BYTES-1:0][7:0]  rdata_o
);
  logic [LINE_BYTES-1:0][7:0] mem_q [NUM_SETS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < LINE_BYTES; b++)
        if (wbe_i[b]) mem_q[widx_i][b] <= wdata_i[b];
    end
  end

  assign rdata_o = mem_q[ridx_i];
endmodule

module dc_data_array_param #(
  parameter int NUM_WAYS     = 2,
  parameter int NUM_SETS     = 16,
  parameter int LINE_BYTES   = 16,
  parameter int STARVE_LIMIT = 4,
  localparam int IDX_W  = $clog2(NUM_SETS),
  localparam int LINE_W = 8 * LINE_BYTES,
  localparam int SW     = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           rd_req_i,
  output logic                           rd_ready_o,
  input  logic [IDX_W-1:0]               rd_index_i,
  output logic                           rd_valid_o,
  output logic [NUM_WAYS*LINE_W-1:0]     rd_data_o,
  input  logic                           wr_req_i,
  output logic                           wr_ready_o,
  input  logic [IDX_W-1:0]               wr_index_i,
  input  logic [NUM_WAYS*LINE_BYTES-1:0] wr_mask_i,
  input  logic [LINE_W-1:0]              wr_data_i,
  output logic                           init_done_o
);
  typedef enum logic {INIT, RUN} state_t;

  typedef logic [LINE_BYTES-1:0][7:0] line_t;

  state_t                               state_q;
  logic [IDX_W-1:0]                     sweep_q;
  logic                                 buf_full_q;
  logic [IDX_W-1:0]                     buf_idx_q;
  logic [NUM_WAYS-1:0][LINE_BYTES-1:0]  buf_mask_q;
  line_t                                buf_data_q;
  logic [SW-1:0]                        starve_q;
  logic                                 rd_valid_q;
  logic [NUM_WAYS-1:0][LINE_BYTES-1:0][7:0] rd_data_q, rd_data_d;

  logic run, force_drain, rd_acc, wr_acc, drain;

  assign run         = (state_q == RUN);
  assign force_drain = run & buf_full_q & (starve_q == SW'(STARVE_LIMIT));
  assign rd_ready_o  = run & ~force_drain;
  assign rd_acc      = rd_req_i & rd_ready_o;
  assign drain       = run & buf_full_q & ~rd_acc;
  assign wr_ready_o  = run & (~buf_full_q | drain);
  assign wr_acc      = wr_req_i & wr_ready_o;

  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign init_done_o = run;

  // Single array port: the sweep owns it in INIT, drains own it in RUN
  // (a drain never coincides with an accepted read).
  logic                                 arr_we;
  logic [IDX_W-1:0]                     arr_widx;
  logic [NUM_WAYS-1:0][LINE_BYTES-1:0]  arr_wbe;
  line_t                                arr_wdata;
  logic [NUM_WAYS-1:0][LINE_BYTES-1:0][7:0] arr_rdata;

  always_comb begin
    arr_we    = 1'b0;
    arr_widx  = buf_idx_q;
    arr_wbe   = buf_mask_q;
    arr_wdata = buf_data_q;
    if (!run) begin
      arr_we    = 1'b1;
      arr_widx  = sweep_q;
      arr_wbe   = '1;
      arr_wdata = '0;
    end else if (drain) begin
      arr_we    = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    dc_data_array_way #(
      .NUM_SETS  (NUM_SETS),
      .LINE_BYTES(LINE_BYTES),
      .IDX_W     (IDX_W)
    ) u_way (
      .clk_i  (clk_i),
      .we_i   (arr_we),
      .widx_i (arr_widx),
      .wbe_i  (arr_wbe[g]),
      .wdata_i(arr_wdata),
      .ridx_i (rd_index_i),
      .rdata_o(arr_rdata[g])
    );
  end

  // A read hitting the staged entry sees its masked bytes over the array.
  always_comb begin
    rd_data_d = arr_rdata;
    if (buf_full_q && (buf_idx_q == rd_index_i)) begin
      for (int w = 0; w < NUM_WAYS; w++)
        for (int b = 0; b < LINE_BYTES; b++)
          if (buf_mask_q[w][b]) rd_data_d[w][b] = buf_data_q[b];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= INIT;
      sweep_q    <= '0;
      buf_full_q <= 1'b0;
      buf_idx_q  <= '0;
      buf_mask_q <= '0;
      buf_data_q <= '0;
      starve_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      case (state_q)
        INIT: begin
          rd_valid_q <= 1'b0;
          sweep_q    <= sweep_q + 1'b1;
          if (sweep_q == IDX_W'(NUM_SETS - 1)) state_q <= RUN;
        end
        default: begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= rd_data_d;
          if (wr_acc) begin
            buf_full_q <= 1'b1;
            buf_idx_q  <= wr_index_i;
            buf_mask_q <= wr_mask_i;
            buf_data_q <= wr_data_i;
          end else if (drain) begin
            buf_full_q <= 1'b0;
          end
          if (drain)                    starve_q <= '0;
          else if (buf_full_q && rd_acc) starve_q <= starve_q + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dc_data_array_param.sv
// Randomized scoreboard bench for dc_data_array_param against a byte-level
// cache model where a write becomes visible to reads from the following cycle.

module tb_dc_data_array_param;
  localparam int NW = 2, NS = 16, LB = 16, SL = 4;
  localparam int IW = 4, LW = 8 * LB, MW = NW * LB, DW = NW * LW;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req, rd_ready, rd_valid, wr_req, wr_ready, init_done;
  logic [IW-1:0] rd_index, wr_index;
  logic [DW-1:0] rd_data;
  logic [MW-1:0] wr_mask;
  logic [LW-1:0] wr_data;

  dc_data_array_param #(
    .NUM_WAYS(NW), .NUM_SETS(NS), .LINE_BYTES(LB), .STARVE_LIMIT(SL)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .rd_req_i(rd_req), .rd_ready_o(rd_ready), .rd_index_i(rd_index),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .wr_req_i(wr_req), .wr_ready_o(wr_ready), .wr_index_i(wr_index),
    .wr_mask_i(wr_mask), .wr_data_i(wr_data),
    .init_done_o(init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: plain byte array per set/way.
  logic [7:0] mem_m [NS][NW][LB];

  typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
  exp_t q[$];

  function automatic logic [DW-1:0] model_line(input logic [IW-1:0] idx);
    logic [DW-1:0] l;
    l = '0;
    for (int w = 0; w < NW; w++)
      for (int b = 0; b < LB; b++)
        l[(w*LB+b)*8 +: 8] = mem_m[idx][w][b];
    return l;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        for (int b = 0; b < LB; b++) mem_m[s][w][b] = 8'h00;
  endtask

  // One clock: drive at negedge, judge acceptance, update scoreboard/model.
  task automatic step(input logic rr, input logic [IW-1:0] ri,
                      input logic wr, input logic [IW-1:0] wi,
                      input logic [MW-1:0] wm, input logic [LW-1:0] wd,
                      output logic racc, output logic wacc, output logic wrdy);
    exp_t e;
    @(negedge clk);
    rd_req = rr; rd_index = ri; wr_req = wr; wr_index = wi; wr_mask = wm; wr_data = wd;
    #1;
    racc = rr & rd_ready;
    wacc = wr & wr_ready;
    wrdy = wr_ready;
    if (racc) begin
      e.data = model_line(ri);
      e.cyc  = cyc;
      q.push_back(e);
    end
    if (wacc)
      for (int w = 0; w < NW; w++)
        for (int b = 0; b < LB; b++)
          if (wm[w*LB+b]) mem_m[wi][w][b] = wd[b*8 +: 8];
  endtask

  task automatic idle(input int n);
    logic a, b, c;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, '0, a, b, c);
  endtask

  task automatic rd(input logic [IW-1:0] idx, output logic acc);
    logic b, c;
    step(1'b1, idx, 1'b0, '0, '0, '0, acc, b, c);
  endtask

  task automatic wt(input logic [IW-1:0] idx, input logic [MW-1:0] m,
                    input logic [LW-1:0] d, output logic acc);
    logic a, c;
    step(1'b0, '0, 1'b1, idx, m, d, a, acc, c);
  endtask

  task automatic wait_init(input int expect_cycles, input bit count_ready);
    int k, seen;
    seen = 0;
    for (k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (init_done) begin
        rd_req = 1'b0;
        break;
      end
      if (rd_ready) seen++;
    end
    chk("init_cycles", k, expect_cycles);
    if (count_ready) chk("rd_ready_during_init", seen, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rd_valid) begin
      if (q.size() == 0) chk("rd_valid_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("rd_data", rd_data, e.data);
        chk("rd_latency", cyc, e.cyc + 1);
      end
    end
  end

  initial begin
    logic a, b, c;
    logic prr, pwr;
    logic [IW-1:0] pri, pwi;
    logic [MW-1:0] pwm;
    logic [LW-1:0] pwd;

    rst = 1'b1; rd_req = 1'b1; rd_index = 4'd5; wr_req = 1'b0; wr_index = '0;
    wr_mask = '0; wr_data = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset_rd_ready", rd_ready, 0);
    chk("reset_wr_ready", wr_ready, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_init_done", init_done, 0);
    rst = 1'b0;
    wait_init(NS, 1'b1);

    // Swept array reads as zero.
    rd(4'd5, a);
    chk("read5_accepted", a, 1);
    idle(2);

    // Way0-only write, read two cycles later.
    wt(4'd3, 32'h0000_FFFF, {16{8'hA5}}, a);
    chk("wr3_accepted", a, 1);
    idle(2);
    rd(4'd3, a);
    idle(2);

    // Bypass from the staged entry.
    wt(4'd7, 32'h0001_0000, 128'h3C, a);
    rd(4'd7, a);
    chk("bypass_read_accepted", a, 1);
    idle(3);

    // Starvation: full buffer, reads held for 10 cycles.
    wt(4'd11, {MW{1'b1}}, {$urandom, $urandom, $urandom, $urandom}, a);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 4'd11, 1'b0, '0, '0, '0, a, b, c);
      chk($sformatf("starve_rd_ready_c%0d", i), a, (i == SL + 1) ? 1'b0 : 1'b1);
      chk($sformatf("starve_wr_ready_c%0d", i), c, (i >= SL + 1) ? 1'b1 : 1'b0);
    end
    idle(2);

    // Alternating write/read on one set.
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0)
        step(1'b0, '0, 1'b1, 4'd2, MW'($urandom),
             {$urandom, $urandom, $urandom, $urandom}, a, b, c);
      else
        step(1'b1, 4'd2, 1'b1, 4'd2, MW'($urandom),
             {$urandom, $urandom, $urandom, $urandom}, a, b, c);
    end

    // Random traffic with held requests on a few colliding sets.
    prr = 1'b0; pwr = 1'b0; pri = '0; pwi = '0; pwm = '0; pwd = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!prr) begin
        prr = ($urandom_range(0, 99) < 65);
        pri = IW'($urandom_range(0, 3));
      end
      if (!pwr) begin
        pwr = ($urandom_range(0, 99) < 55);
        pwi = IW'($urandom_range(0, 3));
        pwm = ($urandom_range(0, 9) == 0) ? '0 : MW'($urandom);
        pwd = {$urandom, $urandom, $urandom, $urandom};
      end
      step(prr, pri, pwr, pwi, pwm, pwd, a, b, c);
      if (a) prr = 1'b0;
      if (b) pwr = 1'b0;
    end
    idle(2);
    for (int s = 0; s < NS; s++) rd(IW'(s), a);
    idle(2);

    // Reset with a staged write and a read in flight.
    wt(4'd9, {MW{1'b1}}, {16{8'hFF}}, a);
    rd(4'd9, a);
    @(posedge clk);
    #2;
    rst = 1'b1;
    rd_req = 1'b0; wr_req = 1'b0;
    #1;
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_init_done", init_done, 0);
    chk("midrst_wr_ready", wr_ready, 0);
    q.delete();
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    wait_init(NS, 1'b0);
    rd(4'd9, a);
    chk("post_reset_read_accepted", a, 1);
    for (int s = 0; s < NS; s++) rd(IW'(s), a);
    idle(3);
    chk("scoreboard_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
